instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and loader for the single-cycle MIPS core: the encoding-side counterpart of the main decoder. It accepts operation descriptors (op kind plus register, immediate and target fields) over a valid/ready handshake. It packs each descriptor into a 32-bit MIPS word using the shared opcode constants and writes the word sequentially into instruction memory through a registered write port. It sits between the test/boot infrastructure and the instruction memory, so programs can be built in hardware without an external image.

## Interface
- ADDR_W, 8, word-address width of instruction memory; capacity is 2^ADDR_W words
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: load base_addr, clear count/err, enter RUN
- base_addr  in  ADDR_W  first word address of the program
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- op_kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 J, 4 BEQ, 5 ADDI, 6 LUI, 7 ORI; 8–15 illegal
- rs, rt, rd, shamt  in  5 each  register and shift fields
- funct  in  6  R-type function code
- imm  in  16  I-type immediate
- target  in  26  J-type word target
- seal  in  1  one-cycle pulse: append halt word (J to own address), enter DONE
- imem_we  out  1  write strobe, one cycle per written word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since start, including the halt word
- busy, full, done, err  out  1 each  state flags; err is sticky

## Operation
- States: IDLE, RUN, FULL, DONE. The busy flag is 1 in RUN.
- Reset: state IDLE; imem_we, imem_addr, imem_wdata, count, full, done and err are 0; in_ready is 0.
- start is honoured in every state. On start: addr_ptr <= base_addr, count <= 0, err <= 0, state <= RUN. in_ready is 0 during the start cycle.
- in_ready is 1 only when state is RUN and neither start nor seal is asserted.
- Encoding rules:
  - RTYPE: {6'b000000, rs, rt, rd, shamt, funct}.
  - LW, SW, BEQ, ADDI, ORI: {opcode, rs, rt, imm}.
  - LUI: {6'b001111, 5'b0, rt, imm}; rs is ignored.
  - J: {6'b000010, target}.
  - Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000, ORI 001101.
- Accepted legal descriptor: on the next edge, imem_we <= 1, imem_addr <= addr_ptr, imem_wdata <= encoding, addr_ptr <= addr_ptr + 1, count <= count + 1.
- Accepted illegal descriptor (op_kind ≥ 8): consumed, no write, err <= 1, addr_ptr unchanged.
- Writing to address 2^ADDR_W−1: state <= FULL and full <= 1. addr_ptr does not wrap and no further writes occur.
- seal in RUN: writes {6'b000010, zero-extended addr_ptr} at addr_ptr, count + 1, state <= DONE, done <= 1. seal has priority over a simultaneous descriptor, which is not accepted.
- seal in IDLE, FULL or DONE is ignored.
- start with seal in the same cycle: start wins and seal is ignored.
- Descriptor fields are sampled only on the accept edge.

## Timing
- Write latency is 1 cycle after the accept edge; imem_we is high for exactly 1 cycle per word.
- Throughput is 1 descriptor per cycle back-to-back with no bubbles.
- in_ready is combinational from state, start and seal only, never from in_valid.
- full and done rise on the same edge as the final imem_we.
- Reset asserted mid-program: all outputs go to their reset values immediately. Any in-flight write strobe is dropped.

## Configuration
- INSTR_ENC_BEQ_ABS_EN defined: the BEQ imm is an absolute word address. The encoded offset is imm − (addr_ptr + 1), truncated to 16 bits.
- INSTR_ENC_BEQ_ABS_EN undefined: the BEQ imm is written through unchanged as a PC-relative offset. All other ops are unaffected either way.

## Structure
- Opcode and funct constants come from the shared funct_codes include, the same definitions the decoder uses.
- op_kind encodings (values 0–7) are added to the same shared include.
- One combinational sub-module, instr_field_pack (descriptor + addr_ptr -> 32-bit word, legal flag), holds all encoding rules. The top holds the FSM, pointer, counter and output registers.

## Test plan
- start with base_addr 0, then ADDI rs=1 rt=2 imm=0x0005 -> next cycle imem_we=1, addr 0, wdata 0x20220005, count 1.
- Back-to-back RTYPE rs=1 rt=2 rd=3 funct=0x20 then LUI rt=4 imm=0x1234 -> 0x00221820 at addr 0 and 0x3C041234 at addr 1 on consecutive cycles. J target=0x10 -> 0x08000010.
- ADDR_W=2, base 0, six valid descriptors -> four writes (addr 0–3), full=1 with the fourth write, in_ready=0 thereafter, count 4.
- op_kind=15 followed by ORI rt=1 imm=0xFF -> no write for the first, err=1, ORI word 0x340100FF lands at addr 0. The next start clears err.
- Five legal writes from base 0, then seal together with in_valid -> 0x08000005 at addr 5, descriptor not accepted, done=1, count 6.
- BEQ rs=1 rt=2 imm=2 at addr 4 -> 0x1022FFFD with INSTR_ENC_BEQ_ABS_EN defined, 0x10220002 without it.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, op_kind encodings and FSM state type for the
// MIPS instruction encoder (the encoding-side mirror of the decoder's constants).
package instr_encoder_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    OPK_RTYPE = 4'd0,
    OPK_LW    = 4'd1,
    OPK_SW    = 4'd2,
    OPK_J     = 4'd3,
    OPK_BEQ   = 4'd4,
    OPK_ADDI  = 4'd5,
    OPK_LUI   = 4'd6,
    OPK_ORI   = 4'd7
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  // Kinds 8..15 have no encoding.
  function automatic logic op_kind_legal(input logic [3:0] kind);
    return (kind[3] == 1'b0);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational descriptor-to-word packer holding every encoding rule.
// INSTR_ENC_BEQ_ABS_EN: BEQ imm is an absolute word address converted to an offset.
module instr_field_pack
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] addr_ptr,
  output logic [31:0]       word,
  output logic              legal
);

  logic [15:0] beq_imm_s;

`ifdef INSTR_ENC_BEQ_ABS_EN
  logic [15:0] next_pc_s;

  // Offset is relative to the word after the branch, wrapped to 16 bits.
  assign next_pc_s = 16'(addr_ptr) + 16'd1;
  assign beq_imm_s = imm - next_pc_s;
`else
  logic unused_ptr_s;

  assign unused_ptr_s = ^addr_ptr;
  assign beq_imm_s    = imm;
`endif

  // Select the field layout for the requested kind
  always_comb begin
    word  = 32'h0000_0000;
    legal = op_kind_legal(op_kind);
    case (op_kind)
      OPK_RTYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
      OPK_LW:    word = {OPC_LW, rs, rt, imm};
      OPK_SW:    word = {OPC_SW, rs, rt, imm};
      OPK_J:     word = {OPC_J, target};
      OPK_BEQ:   word = {OPC_BEQ, rs, rt, beq_imm_s};
      OPK_ADDI:  word = {OPC_ADDI, rs, rt, imm};
      OPK_LUI:   word = {OPC_LUI, 5'b00000, rt, imm};
      OPK_ORI:   word = {OPC_ORI, rs, rt, imm};
      default:   word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: accepts descriptors, writes packed MIPS words
// sequentially into instruction memory. Optional macro: INSTR_ENC_BEQ_ABS_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              seal,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_e        state_r, state_s;
  logic [ADDR_W-1:0] addr_ptr_r, addr_ptr_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic              err_r, err_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] waddr_r, waddr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [31:0]       enc_word_s;
  logic              enc_legal_s;
  logic              ready_s;
  logic              accept_s;

  instr_field_pack #(
    .ADDR_W (ADDR_W)
  ) u_pack (
    .op_kind  (op_kind),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .target   (target),
    .addr_ptr (addr_ptr_r),
    .word     (enc_word_s),
    .legal    (enc_legal_s)
  );

  // start and seal both steal the cycle, so the source must hold its descriptor.
  assign ready_s  = (state_r == ST_RUN) && !start && !seal;
  assign accept_s = in_valid && ready_s;

  // Next-state, pointer, counter and write-port decisions
  always_comb begin
    state_s    = state_r;
    addr_ptr_s = addr_ptr_r;
    count_s    = count_r;
    err_s      = err_r;
    we_s       = 1'b0;
    waddr_s    = waddr_r;
    wdata_s    = wdata_r;
    if (start) begin
      state_s    = ST_RUN;
      addr_ptr_s = base_addr;
      count_s    = {(ADDR_W+1){1'b0}};
      err_s      = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (seal) begin
            // Halt word is a jump to its own address.
            we_s    = 1'b1;
            waddr_s = addr_ptr_r;
            wdata_s = {OPC_J, 26'(addr_ptr_r)};
            count_s = count_r + COUNT_ONE;
            state_s = ST_DONE;
          end else if (accept_s) begin
            if (enc_legal_s) begin
              we_s    = 1'b1;
              waddr_s = addr_ptr_r;
              wdata_s = enc_word_s;
              count_s = count_r + COUNT_ONE;
              if (addr_ptr_r == LAST_ADDR) begin
                state_s = ST_FULL;
              end else begin
                addr_ptr_s = addr_ptr_r + PTR_ONE;
              end
            end else begin
              err_s = 1'b1;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_IDLE, ST_FULL, ST_DONE: state_s = state_r;
        default:                   state_s = ST_IDLE;
      endcase
    end
  end

  // State, pointer, counter and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_ptr_r <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      err_r      <= 1'b0;
      we_r       <= 1'b0;
      waddr_r    <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      addr_ptr_r <= addr_ptr_s;
      count_r    <= count_s;
      err_r      <= err_s;
      we_r       <= we_s;
      waddr_r    <= waddr_s;
      wdata_r    <= wdata_s;
    end
  end

  assign in_ready   = ready_s;
  assign imem_we    = we_r;
  assign imem_addr  = waddr_r;
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign err        = err_r;
  assign busy       = (state_r == ST_RUN);
  assign full       = (state_r == ST_FULL);
  assign done       = (state_r == ST_DONE);

endmodule
